// File: rtl/cpu_stack_pkg.sv
// Shared definitions for the stack-operation controller: command codes,
// stack-pointer control words, FSM states and the per-state bus/stack
// control decode.
package cpu_stack_pkg;

  // Requester command codes.
  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_POP    = 2'b01;
  localparam logic [1:0] OP_PEEK   = 2'b10;
  localparam logic [1:0] OP_READSP = 2'b11;

  // Stack-pointer control words, bit order [0:2]; bit 0 is "drive SP on bus".
  localparam logic [0:2] SPC_HOLD  = 3'b000;
  localparam logic [0:2] SPC_INC   = 3'b010;
  localparam logic [0:2] SPC_DEC   = 3'b001;
  localparam logic [0:2] SPC_DRIVE = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PUSH_WR  = 4'd1,
    ST_PUSH_INC = 4'd2,
    ST_POP_DEC  = 4'd3,
    ST_POP_RD   = 4'd4,
    ST_PEEK_DEC = 4'd5,
    ST_PEEK_RD  = 4'd6,
    ST_PEEK_INC = 4'd7,
    ST_RSP      = 4'd8,
    ST_FIN      = 4'd9
  } stk_state_e;

  typedef struct packed {
    logic [0:2] sp_ctrl;
    logic       mem_w;
    logic       mem_s;
    logic       bus_oe;
  } stk_ctrl_t;

  // Nothing driven, memory released, SP held.
  localparam stk_ctrl_t CTRL_IDLE = '{sp_ctrl: SPC_HOLD, mem_w: 1'b0, mem_s: 1'b1, bus_oe: 1'b0};

  // Bus and stack controls presented while the FSM sits in state s.
  // Each state enables at most one bus driver.
  function automatic stk_ctrl_t ctrl_of(input stk_state_e s);
    stk_ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_PUSH_WR: begin
        c.bus_oe = 1'b1;
        c.mem_w  = 1'b1;
      end
      ST_PUSH_INC, ST_PEEK_INC: c.sp_ctrl = SPC_INC;
      ST_POP_DEC,  ST_PEEK_DEC: c.sp_ctrl = SPC_DEC;
      ST_POP_RD,   ST_PEEK_RD:  c.mem_s   = 1'b0;
      ST_RSP:                   c.sp_ctrl = SPC_DRIVE;
      default:                  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stack_depth_counter.sv
// Up/down entry counter with full/empty flags for the memory stack.
module stack_depth_counter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        dec_i,
  output logic [15:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam logic [15:0] DEPTH_C = 16'(DEPTH);

  logic [15:0] count_q;

  // Count entries; saturating guards keep the count inside 0..DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 16'd0;
    end else if (inc_i && !full_o) begin
      count_q <= count_q + 16'd1;
    end else if (dec_i && !empty_o) begin
      count_q <= count_q - 16'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == 16'd0);

endmodule

// File: rtl/stack_op_controller.sv
// Stack-operation controller: turns PUSH/POP/PEEK/READ_SP requests into
// strobe sequences for the stack pointer and memory stack, owning the
// shared bus for the duration of each command.
module stack_op_controller
  import cpu_stack_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic [15:0]       o_depth,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_oe,
  output logic [0:2]        o_sp_ctrl,
  output logic              o_mem_w,
  output logic              o_mem_s
);

  stk_state_e        state_q, state_d;
  logic              rej_q, rej_d;
  logic              ready_q, done_q, err_q;
  stk_ctrl_t         ctl_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              full_s, empty_s, accept_s, reject_s;
  logic              inc_s, dec_s, capture_s;

  assign accept_s  = i_valid && ready_q;
  assign reject_s  = ((i_op == OP_PUSH) && full_s) ||
                     (((i_op == OP_POP) || (i_op == OP_PEEK)) && empty_s);
  // Depth follows the SP only for POP/PUSH; PEEK restores SP and leaves it.
  assign inc_s     = (state_q == ST_PUSH_INC);
  assign dec_s     = (state_q == ST_POP_DEC);
  assign capture_s = (state_q == ST_POP_RD) || (state_q == ST_PEEK_RD) || (state_q == ST_RSP);

  stack_depth_counter #(.DEPTH(DEPTH)) u_depth (
    .clk_i   (i_clock),
    .rst_ni  (i_reset_n),
    .inc_i   (inc_s),
    .dec_i   (dec_s),
    .count_o (o_depth),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next-state sequencing; rejected commands go straight to FIN with the error flag.
  always_comb begin
    state_d = state_q;
    rej_d   = rej_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (reject_s) begin
            state_d = ST_FIN;
            rej_d   = 1'b1;
          end else begin
            rej_d = 1'b0;
            case (i_op)
              OP_PUSH:   state_d = ST_PUSH_WR;
              OP_POP:    state_d = ST_POP_DEC;
              OP_PEEK:   state_d = ST_PEEK_DEC;
              OP_READSP: state_d = ST_RSP;
              default:   state_d = ST_IDLE;
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUSH_WR:  state_d = ST_PUSH_INC;
      ST_PUSH_INC: state_d = ST_FIN;
      ST_POP_DEC:  state_d = ST_POP_RD;
      ST_POP_RD:   state_d = ST_FIN;
      ST_PEEK_DEC: state_d = ST_PEEK_RD;
      ST_PEEK_RD:  state_d = ST_PEEK_INC;
      ST_PEEK_INC: state_d = ST_FIN;
      ST_RSP:      state_d = ST_FIN;
      ST_FIN: begin
        state_d = ST_IDLE;
        rej_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rej_d   = 1'b0;
      end
    endcase
  end

  // FSM state plus outputs registered from the state being entered.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      rej_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ctl_q   <= CTRL_IDLE;
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      rej_q   <= rej_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_FIN) && !rej_d;
      err_q   <= (state_d == ST_FIN) && rej_d;
      ctl_q   <= ctrl_of(state_d);
      if (accept_s) begin
        wdata_q <= i_wdata;
      end else begin
        wdata_q <= wdata_q;
      end
      if (capture_s) begin
        rdata_q <= i_bus;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  assign o_ready    = ready_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_rdata    = rdata_q;
  assign o_bus_data = wdata_q;
  assign o_bus_oe   = ctl_q.bus_oe;
  assign o_sp_ctrl  = ctl_q.sp_ctrl;
  assign o_mem_w    = ctl_q.mem_w;
  assign o_mem_s    = ctl_q.mem_s;

endmodule

// File: tb/tb_stack_op_controller.sv
// Scoreboard bench for stack_op_controller with a behavioural stack model,
// a bench-side stack pointer / memory, directed cases and a random run.
module tb_stack_op_controller;
  import cpu_stack_pkg::*;

  localparam int unsigned TB_DEPTH = 4;

  logic        i_clock   = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_valid   = 1'b0;
  logic [1:0]  i_op      = 2'b00;
  logic [15:0] i_wdata   = 16'h0000;
  logic        o_ready, o_done, o_err, o_bus_oe, o_mem_w, o_mem_s;
  logic [15:0] o_rdata, o_depth, o_bus_data, i_bus;
  logic [0:2]  o_sp_ctrl;

  stack_op_controller #(.DEPTH(TB_DEPTH), .DATA_W(16)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_op(i_op),
    .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_depth(o_depth), .i_bus(i_bus), .o_bus_data(o_bus_data),
    .o_bus_oe(o_bus_oe), .o_sp_ctrl(o_sp_ctrl), .o_mem_w(o_mem_w), .o_mem_s(o_mem_s)
  );

  always #5 i_clock = ~i_clock;

  // Environment: stack pointer register and memory stack (not reset by the DUT).
  logic [15:0] env_sp = 16'h0040;
  logic [15:0] env_mem [65536];
  int unsigned cyc = 0;

  assign i_bus = o_bus_oe ? o_bus_data :
                 (!o_mem_s ? env_mem[env_sp] :
                 (o_sp_ctrl[0] ? env_sp : 16'h0000));

  always @(posedge i_clock) begin
    cyc <= cyc + 1;
    if (cyc > 0) begin
      if (o_mem_w) env_mem[env_sp] <= i_bus;
      if (o_sp_ctrl == SPC_INC) env_sp <= env_sp + 16'd1;
      else if (o_sp_ctrl == SPC_DEC) env_sp <= env_sp - 16'd1;
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Scoreboard entries.
  typedef struct {
    logic        is_err;
    logic [15:0] rdata;
    logic [15:0] depth;
    logic [15:0] sp;
    int unsigned due;
    int unsigned snap;
    logic        chk_mem;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Behavioural reference: a plain queue of entries plus the SP of the empty stack.
  logic [15:0] ref_stk[$];
  logic [15:0] ref_base  = 16'h0040;
  logic [15:0] ref_rdata = 16'h0000;
  int unsigned strobe_cnt = 0;

  // Per-cycle bus-exclusivity / write-strobe checks and strobe counting.
  always @(negedge i_clock) begin
    if (cyc > 0) begin
      chk("bus_exclusive", 32'(($countones({o_bus_oe, ~o_mem_s, o_sp_ctrl[0]}) <= 1)), 32'd1);
      chk("memw_needs_oe", 32'(!(o_mem_w && !o_bus_oe)), 32'd1);
      if ((o_sp_ctrl != SPC_HOLD) || o_mem_w) strobe_cnt <= strobe_cnt + 1;
    end
  end

  // Monitor: pop and compare whenever a done/err pulse is presented.
  always @(negedge i_clock) begin
    if ((cyc > 0) && (o_done || o_err)) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", 32'({o_done, o_err}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_err_kind", 32'({o_done, o_err}), mon_e.is_err ? 32'd1 : 32'd2);
        chk("latency", cyc, mon_e.due);
        chk("rdata", 32'(o_rdata), 32'(mon_e.rdata));
        chk("depth", 32'(o_depth), 32'(mon_e.depth));
        chk("sp", 32'(env_sp), 32'(mon_e.sp));
        if (mon_e.chk_mem) chk("mem_write", 32'(env_mem[mon_e.mem_addr]), 32'(mon_e.mem_data));
        if (mon_e.is_err) chk("err_no_strobes", strobe_cnt, mon_e.snap);
      end
    end
  end

  task automatic tick();
    @(negedge i_clock);
    #1;
  endtask

  // While busy the requester may wiggle anything; it must be ignored.
  task automatic drive_idle();
    i_op    = 2'($urandom);
    i_wdata = 16'($urandom);
    i_valid = o_ready ? 1'b0 : 1'($urandom);
  endtask

  task automatic model(input logic [1:0] op, input logic [15:0] d, output exp_t e);
    int unsigned lat;
    e.is_err = 1'b0; e.chk_mem = 1'b0; e.mem_addr = 16'h0000; e.mem_data = 16'h0000;
    case (op)
      OP_PUSH: begin
        if (ref_stk.size() == TB_DEPTH) begin e.is_err = 1'b1; lat = 1; end
        else begin
          e.chk_mem = 1'b1; e.mem_addr = ref_base + 16'(ref_stk.size()); e.mem_data = d;
          ref_stk.push_back(d); lat = 3;
        end
      end
      OP_POP: begin
        if (ref_stk.size() == 0) begin e.is_err = 1'b1; lat = 1; end
        else begin ref_rdata = ref_stk.pop_back(); lat = 3; end
      end
      OP_PEEK: begin
        if (ref_stk.size() == 0) begin e.is_err = 1'b1; lat = 1; end
        else begin ref_rdata = ref_stk[$]; lat = 4; end
      end
      default: begin ref_rdata = ref_base + 16'(ref_stk.size()); lat = 2; end
    endcase
    e.rdata = ref_rdata;
    e.depth = 16'(ref_stk.size());
    e.sp    = ref_base + 16'(ref_stk.size());
    e.due   = cyc + lat;
    e.snap  = strobe_cnt;
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (!o_ready && n < 30) begin drive_idle(); tick(); n++; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] d);
    exp_t e;
    int unsigned n = 0;
    wait_ready();
    if (!o_ready) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    model(op, d, e);
    sb.push_back(e);
    i_valid = 1'b1; i_op = op; i_wdata = d;
    tick();
    while (sb.size() != 0 && n < 30) begin drive_idle(); tick(); n++; end
    if (sb.size() != 0) begin chk("done_timeout", 32'(sb.size()), 32'd0); sb.delete(); end
    drive_idle();
  endtask

  initial begin
    logic [15:0] sp_before;
    // Reset state.
    repeat (3) tick();
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_depth", 32'(o_depth), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);
    chk("rst_pulses", 32'({o_done, o_err}), 32'd0);
    chk("rst_ctrl", 32'({o_sp_ctrl, o_mem_w, o_mem_s, o_bus_oe}), 32'b000010);
    i_reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(o_ready), 32'd1);

    // READ_SP with SP=0x0040, then PUSH A5A5 and pop it back.
    issue(OP_READSP, 16'h0000);
    issue(OP_PUSH, 16'hA5A5);
    issue(OP_POP, 16'h0000);
    // PUSH/PUSH/POP/PEEK.
    issue(OP_PUSH, 16'h1111);
    issue(OP_PUSH, 16'h2222);
    issue(OP_POP, 16'h0000);
    issue(OP_PEEK, 16'h0000);
    issue(OP_POP, 16'h0000);
    // Underflow on POP and PEEK.
    issue(OP_POP, 16'h0000);
    issue(OP_PEEK, 16'h0000);
    // Overflow: five pushes into a four-entry stack.
    for (int k = 0; k < 5; k++) issue(OP_PUSH, 16'(16'h3000 + k));
    issue(OP_READSP, 16'h0000);

    // Reset during POP_DEC: SP step already taken stays, depth clears.
    wait_ready();
    sp_before = ref_base + 16'(ref_stk.size());
    i_valid = 1'b1; i_op = OP_POP; i_wdata = 16'h0000;
    tick();
    i_valid = 1'b0;
    chk("in_pop_dec", 32'(o_sp_ctrl), 32'(SPC_DEC));
    i_reset_n = 1'b0;
    tick();
    sb.delete();
    ref_stk.delete();
    ref_rdata = 16'h0000;
    ref_base  = sp_before - 16'd1;
    chk("abort_depth", 32'(o_depth), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd0);
    chk("abort_mem_s", 32'(o_mem_s), 32'd1);
    chk("abort_pulses", 32'({o_done, o_err}), 32'd0);
    chk("abort_sp_ctrl", 32'(o_sp_ctrl), 32'd0);
    i_reset_n = 1'b1;
    tick();
    chk("abort_ready_back", 32'(o_ready), 32'd1);
    chk("abort_sp_kept", 32'(env_sp), 32'(ref_base));
    repeat (3) tick();
    issue(OP_READSP, 16'h0000);

    // Random run.
    for (int k = 0; k < 2000; k++) issue(2'($urandom_range(0, 3)), 16'($urandom));
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
